// File: rtl/spi_subperipheral_selector.sv
// Decodes the first SPI byte into a one-hot subperipheral enable and forwards the selected response.
// Optional watchdog on the SELECTED state is compiled in with `define SPI_SELECTOR_TIMEOUT_EN.
module spi_subperipheral_selector #(
  parameter int unsigned                        NUM_SUBPERIPHERALS = 4,
  parameter logic [8*NUM_SUBPERIPHERALS-1:0]    OPCODE_TABLE       = 32'h40_30_20_DB,
  parameter logic [7:0]                         UNMAPPED_RESPONSE  = 8'hFF,
  parameter int unsigned                        TIMEOUT_CYCLES     = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            cs_n,
  input  logic [7:0]                      opcode,
  input  logic                            opcode_valid,
  input  logic                            operand_valid,
  output logic [NUM_SUBPERIPHERALS-1:0]   enable,
  input  logic [8*NUM_SUBPERIPHERALS-1:0] sub_data_in,
  input  logic [NUM_SUBPERIPHERALS-1:0]   sub_data_valid_in,
  output logic [7:0]                      byte_index,
  output logic [7:0]                      data_out,
  output logic                            data_out_valid,
  output logic                            timeout_error
);

  localparam int unsigned N = NUM_SUBPERIPHERALS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DECODE   = 2'd1,
    S_SELECTED = 2'd2,
    S_UNMAPPED = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     opcode_q, opcode_d;
  logic [N-1:0]   enable_q, enable_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic [7:0]     idx_q, idx_d;
  // Cleared by reset; a new transaction may only start after cs_n has been seen high.
  logic           armed_q, armed_d;

  logic [N-1:0]   match_oh_c;
  logic           match_c;
  logic [7:0]     sel_byte_c;
  logic           sel_vld_c;
  logic [7:0]     idx_inc_c;

`ifdef SPI_SELECTOR_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              terr_q, terr_d;
`else
  logic [31:0] unused_timeout_c;
  assign unused_timeout_c = 32'(TIMEOUT_CYCLES);
`endif

  // Lowest-index table entry matching the latched opcode.
  always_comb begin
    match_oh_c = '0;
    match_c    = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!match_c && (OPCODE_TABLE[8*i +: 8] == opcode_q)) begin
        match_oh_c[i] = 1'b1;
        match_c       = 1'b1;
      end
    end
  end

  // Response of the currently enabled subperipheral; all others are ignored.
  always_comb begin
    sel_byte_c = 8'h00;
    sel_vld_c  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (enable_q[i]) begin
        sel_byte_c = sub_data_in[8*i +: 8];
        sel_vld_c  = sub_data_valid_in[i];
      end
    end
  end

  assign idx_inc_c = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    enable_d = enable_q;
    data_d   = data_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    armed_d  = armed_q;
`ifdef SPI_SELECTOR_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    terr_d   = terr_q;
`endif
    if (cs_n) begin
      state_d  = S_IDLE;
      enable_d = '0;
      valid_d  = 1'b0;
      idx_d    = 8'h00;
      armed_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (opcode_valid && armed_q) begin
            opcode_d = opcode;
            idx_d    = 8'h00;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          if (match_c) begin
            state_d  = S_SELECTED;
            enable_d = match_oh_c;
`ifdef SPI_SELECTOR_TIMEOUT_EN
            tcnt_d   = '0;
`endif
          end else begin
            state_d = S_UNMAPPED;
            data_d  = UNMAPPED_RESPONSE;
            valid_d = 1'b1;
          end
        end
        S_SELECTED: begin
          if (operand_valid) idx_d = idx_inc_c;
          if (sel_vld_c) begin
            data_d  = sel_byte_c;
            valid_d = 1'b1;
          end
`ifdef SPI_SELECTOR_TIMEOUT_EN
          else if (!valid_q) begin
            if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
              state_d  = S_UNMAPPED;
              enable_d = '0;
              data_d   = UNMAPPED_RESPONSE;
              valid_d  = 1'b1;
              terr_d   = 1'b1;
            end else begin
              tcnt_d = tcnt_q + TCNT_W'(1);
            end
          end
`endif
        end
        S_UNMAPPED: begin
          if (operand_valid) idx_d = idx_inc_c;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      opcode_q <= 8'h00;
      enable_q <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      idx_q    <= 8'h00;
      armed_q  <= 1'b0;
`ifdef SPI_SELECTOR_TIMEOUT_EN
      tcnt_q   <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      enable_q <= enable_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      armed_q  <= armed_d;
`ifdef SPI_SELECTOR_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      terr_q   <= terr_d;
`endif
    end
  end

  assign enable         = enable_q;
  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign byte_index     = idx_q;
`ifdef SPI_SELECTOR_TIMEOUT_EN
  assign timeout_error  = terr_q;
`else
  assign timeout_error  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_subperipheral_selector.sv
// Randomized scoreboard bench for spi_subperipheral_selector: transaction-level opcode model,
// response queue checked by an independent monitor, plus directed cs_n and reset scenarios.
module tb_spi_subperipheral_selector;

  localparam int unsigned NSUB = 4;
  localparam logic [31:0] TABLE = 32'h40_30_20_DB;
  localparam logic [7:0]  UNMAP = 8'hFF;

  logic            clk;
  logic            rst_n;
  logic            cs_n;
  logic [7:0]      opcode;
  logic            opv;
  logic            operand;
  logic [NSUB-1:0] enable;
  logic [31:0]     sub_data;
  logic [NSUB-1:0] sub_vld;
  logic [7:0]      byte_index;
  logic [7:0]      data_out;
  logic            data_out_valid;
  logic            timeout_error;

  spi_subperipheral_selector #(
    .NUM_SUBPERIPHERALS (NSUB),
    .OPCODE_TABLE       (TABLE),
    .UNMAPPED_RESPONSE  (UNMAP),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .clock             (clk),
    .reset_n           (rst_n),
    .cs_n              (cs_n),
    .opcode            (opcode),
    .opcode_valid      (opv),
    .operand_valid     (operand),
    .enable            (enable),
    .sub_data_in       (sub_data),
    .sub_data_valid_in (sub_vld),
    .byte_index        (byte_index),
    .data_out          (data_out),
    .data_out_valid    (data_out_valid),
    .timeout_error     (timeout_error)
  );

  typedef struct {
    logic [3:0] en;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: index of the first table entry equal to op, -1 when unmapped.
  function automatic int lookup(input logic [7:0] op);
    logic [7:0] ops [4];
    logic [31:0] tbl;
    tbl = TABLE;
    for (int i = 0; i < 4; i++) ops[i] = tbl[8*i +: 8];
    for (int i = 0; i < 4; i++) if (ops[i] == op) return i;
    return -1;
  endfunction

  // Random traffic on every subperipheral except the selected one, which gets the given beat.
  task automatic drive_subs(input int sel, input logic sv, input logic [7:0] sb);
    for (int i = 0; i < 4; i++) begin
      sub_data[8*i +: 8] = 8'($urandom);
      sub_vld[i]         = 1'($urandom);
    end
    if (sel >= 0) begin
      sub_vld[sel]         = sv;
      sub_data[8*sel +: 8] = sb;
    end
  endtask

  // Monitor: every new response presented by the DUT must match the oldest expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (data_out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'(data_out), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_data",  32'(data_out), 32'(e.data));
        check("resp_en",    32'(enable),   32'(e.en));
        check("resp_cycle", 32'(cyc),      32'(e.cyc));
      end
    end
    prev_valid <= data_out_valid;
  end

  task automatic run_txn(input logic [7:0] op, input int nops, input int k, input logic [7:0] b0);
    int         sel;
    int         c0;
    int         sent;
    int         t;
    logic [3:0] exp_en;
    logic [7:0] bytes[$];
    logic [7:0] last;
    exp_t       e;

    sel    = lookup(op);
    exp_en = (sel >= 0) ? 4'(1 << sel) : 4'b0000;
    bytes.push_back(b0);
    for (int i = 1; i < k; i++) bytes.push_back(8'($urandom));
    last = (sel >= 0) ? bytes[k-1] : UNMAP;

    step(); cs_n = 1'b0; opv = 1'b0; operand = 1'($urandom); drive_subs(-1, 1'b0, 8'h00);
    step(); opcode = op; opv = 1'b1; operand = 1'b1; drive_subs(-1, 1'b0, 8'h00);
    c0     = cyc;
    e.en   = exp_en;
    e.data = (sel >= 0) ? b0 : UNMAP;
    e.cyc  = c0 + ((sel >= 0) ? 4 : 2);
    exp_q.push_back(e);

    step(); opv = 1'b0; opcode = 8'($urandom); operand = 1'($urandom); drive_subs(-1, 1'b0, 8'h00);
    @(negedge clk);
    check("en_decode", 32'(enable), 32'h0);

    step();
    t = 0; sent = 0;
    while (sent < nops || t <= k) begin
      opv    = ($urandom % 8 == 0);
      opcode = 8'($urandom);
      operand = (sent < nops) && ($urandom % 4 != 0);
      if (operand) sent++;
      if (t >= 1 && t <= k) drive_subs(sel, 1'b1, bytes[t-1]);
      else                  drive_subs(sel, 1'b0, 8'($urandom));
      if (t == 0) begin
        @(negedge clk);
        check("en_selected", 32'(enable), 32'(exp_en));
      end
      t++;
      step();
    end

    opv = 1'b0; operand = 1'b0; drive_subs(sel, 1'b0, 8'($urandom));
    @(negedge clk);
    check("byte_index", 32'(byte_index), (nops > 255) ? 32'd255 : 32'(nops));
    check("final_data", 32'(data_out), 32'(last));
    check("final_valid", 32'(data_out_valid), 32'h1);
    check("final_en", 32'(enable), 32'(exp_en));
    check("timeout_flag", 32'(timeout_error), 32'h0);

    step(); cs_n = 1'b1;
    step();
    @(negedge clk);
    check("end_en", 32'(enable), 32'h0);
    check("end_valid", 32'(data_out_valid), 32'h0);
    check("end_idx", 32'(byte_index), 32'h0);
    check("end_hold", 32'(data_out), 32'(last));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] ops4[4];
    rst_n = 1'b0; cs_n = 1'b1; opcode = 8'h00; opv = 1'b0; operand = 1'b0;
    sub_data = '0; sub_vld = '0;
    #12;
    check("rst_en", 32'(enable), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_out_valid), 32'h0);
    check("rst_idx", 32'(byte_index), 32'h0);
    check("rst_terr", 32'(timeout_error), 32'h0);
    step(); rst_n = 1'b1;
    step();

    run_txn(8'hDB, 0, 1, 8'h81);
    run_txn(8'h55, 3, 1, 8'h00);
    run_txn(8'h30, 300, 2, 8'h5A);

    // cs_n high wins over a coincident opcode_valid
    step(); cs_n = 1'b1; opcode = 8'hDB; opv = 1'b1;
    step(); cs_n = 1'b0; opv = 1'b0;
    step(); step();
    @(negedge clk);
    check("csn_prio_en", 32'(enable), 32'h0);
    check("csn_prio_valid", 32'(data_out_valid), 32'h0);
    step(); cs_n = 1'b1;

    ops4[0] = 8'hDB; ops4[1] = 8'h20; ops4[2] = 8'h30; ops4[3] = 8'h40;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] op;
      op = ($urandom % 2 == 0) ? ops4[$urandom % 4] : 8'($urandom);
      run_txn(op, $urandom_range(0, 20), $urandom_range(1, 3), 8'($urandom));
    end

    // Reset in the middle of a selected transaction
    step(); cs_n = 1'b0; opcode = 8'h20; opv = 1'b1; drive_subs(1, 1'b0, 8'h00);
    step(); opv = 1'b0;
    step(); step();
    @(negedge clk);
    check("pre_rst_en", 32'(enable), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(enable), 32'h0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(data_out_valid), 32'h0);
    check("mid_rst_idx", 32'(byte_index), 32'h0);
    step(); rst_n = 1'b1;
    step(); opcode = 8'hDB; opv = 1'b1;
    step(); opv = 1'b0;
    step(); step();
    @(negedge clk);
    check("post_rst_no_start", 32'(enable), 32'h0);
    check("post_rst_no_valid", 32'(data_out_valid), 32'h0);
    step(); cs_n = 1'b1;
    run_txn(8'h40, 5, 1, 8'h3C);

`ifdef SPI_SELECTOR_TIMEOUT_EN
    begin
      exp_t e;
      step(); cs_n = 1'b0; opcode = 8'h20; opv = 1'b1; drive_subs(1, 1'b0, 8'h00);
      e.en = 4'b0000; e.data = UNMAP; e.cyc = cyc + 18;
      exp_q.push_back(e);
      step(); opv = 1'b0;
      repeat (18) step();
      @(negedge clk);
      check("wd_terr", 32'(timeout_error), 32'h1);
      check("wd_en", 32'(enable), 32'h0);
      check("wd_data", 32'(data_out), 32'(UNMAP));
      step(); cs_n = 1'b1;
    end
`endif

    repeat (4) step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
